// File: rtl/conv3x3_mac.sv
// conv3x3_mac: 3-stage signed 3x3 convolution with rounding shift, unsigned clamp,
// double-buffered kernel (coef_* load/commit) and saturating clamp counter (sat_cnt).
module conv3x3_mac #(
  parameter int PIX_W  = 8,
  parameter int COEF_W = 8,
  parameter int SHIFT  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [PIX_W-1:0]  w00,
  input  logic [PIX_W-1:0]  w01,
  input  logic [PIX_W-1:0]  w02,
  input  logic [PIX_W-1:0]  w10,
  input  logic [PIX_W-1:0]  w11,
  input  logic [PIX_W-1:0]  w12,
  input  logic [PIX_W-1:0]  w20,
  input  logic [PIX_W-1:0]  w21,
  input  logic [PIX_W-1:0]  w22,
  input  logic              coef_valid,
  input  logic [COEF_W-1:0] coef_data,
  input  logic              coef_commit,
  output logic              coef_full,
  output logic [PIX_W-1:0]  px_out,
  output logic              valid_out,
  output logic [CNT_W-1:0]  sat_cnt,
  input  logic              cnt_clr
);

  localparam int PRD_W = PIX_W + 1 + COEF_W;
  localparam int ROW_W = PRD_W + 2;
  localparam int ACC_W = PIX_W + COEF_W + 5;

  localparam logic signed [COEF_W-1:0] IDENT =
    COEF_W'(1 << SHIFT);
  // Half-LSB rounding constant; zero when SHIFT==0
  localparam logic signed [ACC_W:0] RND =
    (ACC_W+1)'((1 << SHIFT) >> 1);
  localparam logic signed [ACC_W:0] MAXV =
    (ACC_W+1)'((1 << PIX_W) - 1);

  typedef enum logic {
    LOAD,
    FULL
  } ld_state_t;

  ld_state_t state, state_nxt;
  logic [3:0] idx, idx_nxt;
  logic       shadow_we;
  logic       commit;

  logic signed [COEF_W-1:0] shadow [9];
  logic signed [COEF_W-1:0] active [9];
  logic [PIX_W-1:0]         pix [9];

  logic signed [PRD_W-1:0]  prod [9];
  logic                     v1;
  logic signed [ROW_W-1:0]  row [3];
  logic                     v2;

  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W:0]    rnd_v;
  logic                     lo, hi;
  logic [PIX_W-1:0]         clamp_px;

  assign pix = '{w00, w01, w02, w10, w11, w12, w20, w21, w22};
  assign coef_full = (state == FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    shadow_we = 1'b0;
    commit    = 1'b0;
    unique case (state)
      LOAD: begin
        if (coef_valid) begin
          shadow_we = 1'b1;
          if (idx == 4'd8) begin
            state_nxt = FULL;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + 4'd1;
          end
        end
      end
      FULL: begin
        if (coef_commit) begin
          commit    = 1'b1;
          state_nxt = LOAD;
          idx_nxt   = '0;
        end
      end
    endcase
  end

  // Commit and S1 sample share an edge, so a window
  // accepted with the commit still sees the old bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) begin
        shadow[i] <= '0;
        active[i] <= (i == 4) ? IDENT : '0;
      end
    end else begin
      if (shadow_we) shadow[idx] <= coef_data;
      if (commit) begin
        for (int i = 0; i < 9; i++) active[i] <= shadow[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      for (int i = 0; i < 9; i++) prod[i] <= '0;
    end else begin
      v1 <= valid_in;
      for (int i = 0; i < 9; i++) begin
        prod[i] <= PRD_W'($signed({1'b0, pix[i]}))
                 * PRD_W'(active[i]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2 <= 1'b0;
      for (int r = 0; r < 3; r++) row[r] <= '0;
    end else begin
      v2 <= v1;
      for (int r = 0; r < 3; r++) begin
        row[r] <= ROW_W'(prod[3*r])
                + ROW_W'(prod[3*r+1])
                + ROW_W'(prod[3*r+2]);
      end
    end
  end

  always_comb begin
    sum = ACC_W'(row[0]) + ACC_W'(row[1])
        + ACC_W'(row[2]);
    // One guard bit so the rounding add cannot wrap
    rnd_v = ((ACC_W+1)'(sum) + RND) >>> SHIFT;
    lo = (rnd_v < 0);
    hi = (rnd_v > MAXV);
    clamp_px = rnd_v[PIX_W-1:0];
    if (lo) clamp_px = '0;
    if (hi) clamp_px = '1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out <= 1'b0;
      px_out    <= '0;
      sat_cnt   <= '0;
    end else begin
      valid_out <= v2;
      if (v2) px_out <= clamp_px;
      if (cnt_clr) begin
        sat_cnt <= '0;
      end else if (v2 && (lo || hi) && !(&sat_cnt)) begin
        sat_cnt <= sat_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_mac.sv
// tb_conv3x3_mac: scoreboard bench for conv3x3_mac.
// Drives windows/kernels, checks px_out, latency, sat_cnt, coef_full.
module tb_conv3x3_mac;

  localparam int PIX_W  = 8;
  localparam int COEF_W = 8;
  localparam int SHIFT  = 4;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              valid_in = 1'b0;
  logic [PIX_W-1:0]  w00 = '0, w01 = '0, w02 = '0;
  logic [PIX_W-1:0]  w10 = '0, w11 = '0, w12 = '0;
  logic [PIX_W-1:0]  w20 = '0, w21 = '0, w22 = '0;
  logic              coef_valid = 1'b0;
  logic [COEF_W-1:0] coef_data = '0;
  logic              coef_commit = 1'b0;
  logic              coef_full;
  logic [PIX_W-1:0]  px_out;
  logic              valid_out;
  logic [CNT_W-1:0]  sat_cnt;
  logic              cnt_clr = 1'b0;

  int checks = 0;
  int errors = 0;
  int q[$];

  // bench-side kernel model
  int mk[9];
  int sh[9];
  int m_idx;
  bit m_full;

  conv3x3_mac #(
    .PIX_W(PIX_W), .COEF_W(COEF_W),
    .SHIFT(SHIFT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in),
    .w00(w00), .w01(w01), .w02(w02),
    .w10(w10), .w11(w11), .w12(w12),
    .w20(w20), .w21(w21), .w22(w22),
    .coef_valid(coef_valid), .coef_data(coef_data),
    .coef_commit(coef_commit), .coef_full(coef_full),
    .px_out(px_out), .valid_out(valid_out),
    .sat_cnt(sat_cnt), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  // output monitor: pops scoreboard on every valid_out
  always @(negedge clk) begin
    if (!rst && valid_out) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL spurious_valid px_out=%0d with no expected result", px_out);
      end else begin
        int e;
        e = q.pop_front();
        if (px_out !== e[PIX_W-1:0]) begin
          errors++;
          $display("FAIL px_out got %0d expected %0d", px_out, e);
        end
      end
    end
  end

  function automatic int model(input int p[9], input int k[9]);
    int s, r;
    s = 0;
    for (int i = 0; i < 9; i++) s += p[i] * k[i];
    r = (s + ((1 << SHIFT) >> 1)) >>> SHIFT;
    if (r < 0) r = 0;
    if (r > 255) r = 255;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 9; i++) begin
      mk[i] = (i == 4) ? (1 << SHIFT) : 0;
      sh[i] = 0;
    end
    m_idx = 0;
    m_full = 0;
  endtask

  task automatic set_pix(input int p[9]);
    w00 = 8'(p[0]); w01 = 8'(p[1]); w02 = 8'(p[2]);
    w10 = 8'(p[3]); w11 = 8'(p[4]); w12 = 8'(p[5]);
    w20 = 8'(p[6]); w21 = 8'(p[7]); w22 = 8'(p[8]);
  endtask

  task automatic drive(input int p[9]);
    @(negedge clk);
    set_pix(p);
    valid_in = 1'b1;
    q.push_back(model(p, mk));
  endtask

  task automatic idle();
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic drain();
    int n;
    idle();
    n = 0;
    while (q.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected 0", q.size());
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic load_coefs(input int k[9], input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      coef_valid = 1'b1;
      coef_data = 8'(k[i]);
      if (!m_full) begin
        sh[m_idx] = k[i];
        m_idx++;
        if (m_idx == 9) begin
          m_idx = 0;
          m_full = 1;
        end
      end
    end
    @(negedge clk);
    coef_valid = 1'b0;
  endtask

  task automatic do_commit();
    @(negedge clk);
    coef_commit = 1'b1;
    @(negedge clk);
    coef_commit = 1'b0;
    if (m_full) begin
      mk = sh;
      m_full = 0;
    end
  endtask

  task automatic load_commit(input int k[9]);
    load_coefs(k, 0, 8);
    checks++;
    if (coef_full !== 1'b1) begin
      errors++;
      $display("FAIL coef_full_after_load got %0b expected 1", coef_full);
    end
    do_commit();
    checks++;
    if (coef_full !== 1'b0) begin
      errors++;
      $display("FAIL coef_full_after_commit got %0b expected 0", coef_full);
    end
  endtask

  task automatic check_sat(input int exp);
    checks++;
    if (sat_cnt !== 16'(exp)) begin
      errors++;
      $display("FAIL sat_cnt got %0d expected %0d", sat_cnt, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    checks += 4;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid_out got %0b expected 0", valid_out);
    end
    if (px_out !== 8'd0) begin
      errors++;
      $display("FAIL reset_px_out got %0d expected 0", px_out);
    end
    if (sat_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_sat_cnt got %0d expected 0", sat_cnt);
    end
    if (coef_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_coef_full got %0b expected 0", coef_full);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_identity();
    int p[9];
    int n;
    p = '{7, 7, 7, 7, 200, 7, 7, 7, 7};
    drive(p);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) valid_in = 1'b0;
    end while (!valid_out && n < 10);
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL latency got %0d expected 3", n);
    end
    drain();
    check_sat(0);
  endtask

  task automatic test_overflow();
    int k[9];
    int p[9];
    k = '{2, 2, 2, 2, 2, 2, 2, 2, 2};
    p = '{255, 255, 255, 255, 255, 255, 255, 255, 255};
    load_commit(k);
    drive(p);
    drain();
    check_sat(1);
  endtask

  task automatic test_underflow();
    int k[9];
    int p[9];
    k = '{-2, -2, -2, -2, 16, -2, -2, -2, -2};
    load_commit(k);
    p = '{10, 10, 10, 10, 10, 10, 10, 10, 10};
    drive(p);
    drain();
    check_sat(1);
    p = '{100, 100, 100, 100, 0, 100, 100, 100, 100};
    drive(p);
    drain();
    check_sat(2);
  endtask

  task automatic test_rounding();
    int k[9];
    int p[9];
    k = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    load_commit(k);
    p = '{50, 50, 50, 50, 8, 50, 50, 50, 50};
    drive(p);
    p = '{50, 50, 50, 50, 7, 50, 50, 50, 50};
    drive(p);
    drain();
    check_sat(2);
  endtask

  task automatic test_back_to_back();
    int k[9];
    int p[9];
    int ones[9];
    k = '{0, 0, 0, 0, 16, 0, 0, 0, 0};
    ones = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    p = '{16, 16, 16, 16, 16, 16, 16, 16, 16};
    load_commit(k);
    // partial load then commit: must be ignored
    load_coefs(ones, 0, 4);
    do_commit();
    checks++;
    if (coef_full !== 1'b0) begin
      errors++;
      $display("FAIL commit_in_load coef_full got %0b expected 0", coef_full);
    end
    load_coefs(ones, 5, 8);
    checks++;
    if (coef_full !== 1'b1) begin
      errors++;
      $display("FAIL partial_kept coef_full got %0b expected 1", coef_full);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      set_pix(p);
      valid_in = 1'b1;
      coef_commit = (i == 2);
      q.push_back(model(p, mk));
      if (i == 2) begin
        mk = sh;
        m_full = 0;
      end
    end
    @(negedge clk);
    valid_in = 1'b0;
    coef_commit = 1'b0;
    checks++;
    if (coef_full !== 1'b0) begin
      errors++;
      $display("FAIL stream_commit coef_full got %0b expected 0", coef_full);
    end
    drain();
  endtask

  task automatic test_cnt_clr();
    int k[9];
    int p[9];
    k = '{2, 2, 2, 2, 2, 2, 2, 2, 2};
    p = '{255, 255, 255, 255, 255, 255, 255, 255, 255};
    load_commit(k);
    check_sat(2);
    drive(p);
    idle();
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    checks++;
    if (valid_out !== 1'b1) begin
      errors++;
      $display("FAIL clr_cycle valid_out got %0b expected 1", valid_out);
    end
    check_sat(0);
    drain();
    drive(p);
    drain();
    check_sat(1);
  endtask

  task automatic test_reset_mid();
    int p[9];
    bit seen;
    p = '{9, 9, 9, 9, 250, 9, 9, 9, 9};
    drive(p);
    drive(p);
    @(negedge clk);
    valid_in = 1'b0;
    rst = 1'b1;
    q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (valid_out) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_mid valid_out got 1 expected 0");
    end
    check_sat(0);
    p = '{7, 7, 7, 7, 200, 7, 7, 7, 7};
    drive(p);
    drain();
    check_sat(0);
  endtask

  initial begin
    test_reset();
    test_identity();
    test_overflow();
    test_underflow();
    test_rounding();
    test_back_to_back();
    test_cnt_clr();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv3x3_mac.md
Name: conv3x3_mac

Overview:
- Stage directly downstream of the 3x3 line buffer. Consumes its registered window (w00..w22 plus valid) and computes one output pixel per accepted window.
- Computation: signed 3x3 kernel convolution, then rounding right-shift, then clamp to unsigned.
- Kernel coefficients are loaded at runtime into a shadow bank and committed atomically to the active bank, so a stream is never convolved with a half-written kernel.
- Output feeds the pixel writeback or CSR side of the SoC.

Parameters:
- PIX_W, 8, unsigned pixel width, input and output.
- COEF_W, 8, signed two's-complement coefficient width.
- SHIFT, 4, normalisation right-shift, range 0..COEF_W-2.
- CNT_W, 16, width of the saturation counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- valid_in  in  1  window valid, one cycle per window.
- w00,w01,w02,w10,w11,w12,w20,w21,w22  in  PIX_W each  window pixels. Row 0 is oldest; column 2 is newest.
- coef_valid  in  1  write coef_data into the next shadow slot.
- coef_data  in  COEF_W  coefficient, in order k00,k01,k02,k10,...,k22.
- coef_commit  in  1  request copy of the shadow bank to the active bank.
- coef_full  out  1  high when all 9 shadow slots are written and a commit is pending.
- px_out  out  PIX_W  result pixel.
- valid_out  out  1  px_out valid.
- sat_cnt  out  CNT_W  count of clamped results; saturates at all-ones.
- cnt_clr  in  1  synchronous clear of sat_cnt.

Behaviour:
- Reset (asynchronous, active-high) puts the block in this state:
  - valid_out=0, px_out=0, sat_cnt=0, coef_full=0.
  - Load FSM in LOAD with index 0.
  - Pipeline valid bits cleared.
  - Active bank = identity kernel: k11 = 1<<SHIFT, all other coefficients 0. Shadow bank = 0.
- Reset mid-stream discards all in-flight windows. No valid_out appears for them after reset is released.
- Load FSM states:
  - LOAD (idx 0..8): on coef_valid, shadow[idx] <= coef_data and idx++. On the write with idx==8, go to FULL.
  - FULL: coef_full=1 and coef_valid is ignored. On coef_commit, the active bank gets the shadow bank at the clock edge, then go to LOAD with idx=0.
  - coef_commit while in LOAD is ignored, and the partial shadow contents are kept.
  - A commit only replaces the whole active bank; there is no partial update.
- Commit timing:
  - Windows with valid_in on the same cycle as a commit use the OLD active bank.
  - Windows from the following cycle onward use the NEW bank.
  - Coefficients are sampled only in stage 1.
- Pipeline: 3 stages, fixed latency. valid_in at cycle t gives valid_out at t+3. The block accepts one window per cycle with no bubbles and no backpressure.
  - S1: nine products p_ij = {1'b0,w_ij} * k_ij, signed, each PIX_W+1+COEF_W bits. Registered with valid.
  - S2: three row sums, each +2 bits. Registered.
  - S3: total sum s, with ACC_W = PIX_W+COEF_W+5 bits.
    - Rounding: if SHIFT>0, r = (s + (1<<(SHIFT-1))) >>> SHIFT, an arithmetic shift that rounds half toward +inf. If SHIFT==0, r = s.
    - Clamp: r<0 gives 0; r>2^PIX_W-1 gives 2^PIX_W-1; otherwise px_out = r[PIX_W-1:0].
- px_out holds its last value while valid_out=0.
- sat_cnt behaviour:
  - Increments by 1 on each valid_out result that was clamped, in either direction.
  - Holds at 2^CNT_W-1.
  - cnt_clr takes priority over an increment in the same cycle, and the result is 0.
- valid_in=0 cycles insert bubbles; they propagate unchanged, with no spurious valid_out.

Test Plan:
1. Identity after reset: rst pulse, then valid_in with w11=200 and the other pixels=7 -> 3 cycles later valid_out=1, px_out=200, sat_cnt=0.
2. Overflow clamp: load all k=2, then commit. All pixels=255. Sum=4590, (4590+8)>>4=287 -> px_out=255, sat_cnt=1.
3. Underflow and zero: k11=16, all other k=-2.
   - All pixels=10 -> px_out=0, sat_cnt unchanged.
   - w11=0 and other pixels=100 (sum -1600) -> px_out=0, sat_cnt increments.
4. Rounding: identity kernel with k11=1 instead of 16.
   - w11=8 -> (8+8)>>4 = 1, so px_out=1.
   - w11=7 -> (7+8)>>4 = 0, so px_out=0.
5. Commit boundary: stream 5 back-to-back windows (all pixels=16) with valid_in high every cycle. Assert coef_commit (new bank: all k=1) on the cycle of window 3.
   - Outputs are 16,16,16,9,9. The new bank's sum is 144, and (144+8)>>4 = 9.
   - Also check: a commit while in LOAD (after 5 writes) is ignored, and coef_full stays 0.
6. Reset mid-pipeline: assert rst one cycle after 2 valid windows -> no valid_out afterwards, the active bank returns to identity, and sat_cnt=0. cnt_clr together with a clamped result -> sat_cnt=0.
